fs_dither_engine: RTL and testbench

- Streaming Floyd-Steinberg error-diffusion stage, directly downstream of the grayscale pixel_algorithm_unit.
- Consumes 8-bit gray pixels in raster order (x fastest) and emits one binarised pixel (0 or 255) per input pixel.
- Output feeds the result write port of the image memory for SPI readback.
- Holds one row of diffused error (ping-pong row buffers) plus a right-neighbour carry.

---
 rtl/fs_pkg.sv | 35 +++
 rtl/fs_row_buffer.sv | 35 +++
 rtl/fs_dither_engine.sv | 171 +++++++++++++++++
 tb/tb_fs_dither_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared constants, types and helpers for the Floyd-Steinberg dither stage.
// Errors are carried as signed values scaled by 16 so the 7/3/5/1 weights stay integral.
package fs_pkg;

  localparam int IMAGEX    = 64;
  localparam int IMAGEY    = 64;
  localparam int RGB_SIZE  = 8;
  localparam int ERR_W     = 12;
  localparam int THRESHOLD = 128;

  localparam logic [RGB_SIZE-1:0] PIX_WHITE = 8'd255;
  localparam logic [RGB_SIZE-1:0] PIX_BLACK = 8'd0;

  typedef logic signed [ERR_W-1:0] err_t;
  typedef logic [RGB_SIZE-1:0]     pix_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } fs_state_t;

  // Saturate a corrected pixel value back into the 0..255 gray range.
  function automatic pix_t clamp_pix(input logic signed [9:0] v);
    pix_t r;
    if (v < 10'sd0) begin
      r = PIX_BLACK;
    end else if (v > 10'sd255) begin
      r = PIX_WHITE;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fs_row_buffer.sv
// Ping-pong store of diffused error for one row: asynchronous read from one bank,
// two write ports into the other bank (port b only closes out the last column).
module fs_row_buffer
  import fs_pkg::*;
#(
  parameter int DEPTH = fs_pkg::IMAGEX
) (
  input  logic                     clk,
  input  logic                     rd_sel,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output err_t                     rd_data,
  input  logic                     wr_sel,
  input  logic                     wa_en,
  input  logic [$clog2(DEPTH)-1:0] wa_addr,
  input  err_t                     wa_data,
  input  logic                     wb_en,
  input  logic [$clog2(DEPTH)-1:0] wb_addr,
  input  err_t                     wb_data
);

  err_t mem_r [2][DEPTH];

  assign rd_data = mem_r[rd_sel][rd_addr];

  // Error storage write ports; contents need no reset since row 0 never reads them.
  always_ff @(posedge clk) begin
    if (wa_en) begin
      mem_r[wr_sel][wa_addr] <= wa_data;
    end
    if (wb_en) begin
      mem_r[wr_sel][wb_addr] <= wb_data;
    end
  end

endmodule

// File: rtl/fs_dither_engine.sv
// Streaming Floyd-Steinberg binariser: one gray pixel in, one 0/255 pixel out,
// with a single output register stage and one row of diffused error in flight.
module fs_dither_engine
  import fs_pkg::*;
#(
  parameter int IMAGEX    = fs_pkg::IMAGEX,
  parameter int IMAGEY    = fs_pkg::IMAGEY,
  parameter int THRESHOLD = fs_pkg::THRESHOLD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_clear,
  input  logic                      in_valid,
  input  pix_t                      in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output pix_t                      out_data,
  output logic [$clog2(IMAGEX)-1:0] out_x,
  output logic [$clog2(IMAGEY)-1:0] out_y,
  input  logic                      out_ready,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int XW = $clog2(IMAGEX);
  localparam int YW = $clog2(IMAGEY);

  fs_state_t         state_r, state_s;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  err_t              carry_r, accb_r, accbr_r;
  logic              out_valid_r, out_last_r;
  pix_t              out_data_r;
  logic [XW-1:0]     out_x_r;
  logic [YW-1:0]     out_y_r;

  logic              accept_s, last_x_s, last_y_s;
  err_t              rd_data_s, rowerr_s, sum_s, e_s, e7_s, e5_s, e3_s;
  logic signed [9:0] sh_s, v_s;
  pix_t              vclamp_s, q_s;
  logic              wa_en_s, wb_en_s;

  assign in_ready   = (!out_valid_r || out_ready) && !frame_clear;
  assign accept_s   = in_valid && in_ready;
  assign last_x_s   = (x_r == XW'(IMAGEX - 1));
  assign last_y_s   = (y_r == YW'(IMAGEY - 1));

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_x      = out_x_r;
  assign out_y      = out_y_r;
  assign busy       = (state_r == ACTIVE);
  assign frame_done = out_valid_r && out_ready && out_last_r && !frame_clear;

  // Error correction, clamp, threshold and weighted error terms for the current pixel.
  always_comb begin
    rowerr_s = (y_r == '0) ? '0 : rd_data_s;
    sum_s    = carry_r + rowerr_s;
    sh_s     = 10'(sum_s >>> 4'd4);
    v_s      = $signed({2'b00, in_data}) + sh_s;
    vclamp_s = clamp_pix(v_s);
    q_s      = ({1'b0, vclamp_s} >= 9'(THRESHOLD)) ? PIX_WHITE : PIX_BLACK;
    e_s      = $signed({{(ERR_W-RGB_SIZE){1'b0}}, vclamp_s})
             - $signed({{(ERR_W-RGB_SIZE){1'b0}}, q_s});
    e7_s     = (e_s <<< 2'd3) - e_s;
    e5_s     = (e_s <<< 2'd2) + e_s;
    e3_s     = (e_s <<< 2'd1) + e_s;
  end

  // The final row has nobody below it, so its downward error is discarded.
  assign wa_en_s = accept_s && (x_r != '0) && !last_y_s;
  assign wb_en_s = accept_s && last_x_s && !last_y_s;

  fs_row_buffer #(
    .DEPTH (IMAGEX)
  ) u_row_buffer (
    .clk     (clk),
    .rd_sel  (y_r[0]),
    .rd_addr (x_r),
    .rd_data (rd_data_s),
    .wr_sel  (~y_r[0]),
    .wa_en   (wa_en_s),
    .wa_addr (x_r - XW'(1'b1)),
    .wa_data (accb_r + e3_s),
    .wb_en   (wb_en_s),
    .wb_addr (x_r),
    .wb_data (accbr_r + e5_s)
  );

  // Next-state logic: a frame starts with its first pixel and ends with its last.
  always_comb begin
    state_s = state_r;
    if (frame_clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s = ACTIVE;
          end else begin
            state_s = IDLE;
          end
        end
        ACTIVE: begin
          if (accept_s && last_x_s && last_y_s) begin
            state_s = IDLE;
          end else begin
            state_s = ACTIVE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Raster counters, error carries/accumulators and the output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r         <= '0;
      y_r         <= '0;
      carry_r     <= '0;
      accb_r      <= '0;
      accbr_r     <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
      out_x_r     <= '0;
      out_y_r     <= '0;
    end else if (frame_clear) begin
      x_r         <= '0;
      y_r         <= '0;
      carry_r     <= '0;
      accb_r      <= '0;
      accbr_r     <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= q_s;
      out_x_r     <= x_r;
      out_y_r     <= y_r;
      out_last_r  <= last_x_s && last_y_s;
      if (last_x_s) begin
        x_r     <= '0;
        y_r     <= last_y_s ? '0 : (y_r + YW'(1'b1));
        carry_r <= '0;
        accb_r  <= '0;
        accbr_r <= '0;
      end else begin
        x_r     <= x_r + XW'(1'b1);
        carry_r <= e7_s;
        accb_r  <= accbr_r + e5_s;
        accbr_r <= e_s;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_fs_dither_engine.sv
// Scoreboard bench for fs_dither_engine on a 4x2 image: stimulus pushes the
// hand-computed result of each accepted pixel, a monitor pops on every output handshake.
module tb_fs_dither_engine;

  typedef struct {
    logic [7:0] d;
    logic [1:0] x;
    logic       y;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_x;
  logic       out_y;
  logic       out_ready;
  logic       frame_done;
  logic       busy;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         done_cnt  = 0;
  logic [7:0] gold [3][8];

  fs_dither_engine #(
    .IMAGEX    (4),
    .IMAGEY    (2),
    .THRESHOLD (128)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_clear (frame_clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_ready   (out_ready),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Offer one pixel until accepted, recording what the DUT must produce for it.
  task automatic send(input logic [7:0] d, input int kind, input int idx);
    int   waited = 0;
    logic done   = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{gold[kind][idx], 2'(idx % 4), 1'(idx / 4), (idx == 7)});
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          n_tests++;
          n_fail++;
          $display("FAIL send_timeout: pixel %0d never accepted", idx);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_pixels(input logic [7:0] d, input int kind, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      send(d, kind, i);
    end
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got data=%0d x=%0d y=%0d, expected none",
                   out_data, out_x, out_y);
        end else begin
          mon_e = sb_q.pop_front();
          if (out_data !== mon_e.d || out_x !== mon_e.x || out_y !== mon_e.y ||
              frame_done !== mon_e.last) begin
            n_fail++;
            $display("FAIL output: got data=%0d x=%0d y=%0d done=%0b, expected data=%0d x=%0d y=%0d done=%0b",
                     out_data, out_x, out_y, frame_done, mon_e.d, mon_e.x, mon_e.y, mon_e.last);
          end
        end
        if (frame_done) done_cnt++;
      end else if (frame_done) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_frame_done: got 1, expected 0");
      end
    end
  end

  initial begin
    // Row 0 of a flat-128 image alternates; row 1 starts black because row 0 pushed error down.
    gold[0] = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255};
    gold[1] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    gold[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};

    rst         = 1'b1;
    frame_clear = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'd0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_pixels(8'd128, 0, 0, 1);
    check("busy_in_frame", 32'(busy), 32'd1);
    run_pixels(8'd128, 0, 1, 7);
    drain();
    check("busy_after_frame_128", 32'(busy), 32'd0);
    check("done_count_128", 32'(done_cnt), 32'd1);

    run_pixels(8'd0, 1, 0, 8);
    drain();
    check("busy_after_frame_0", 32'(busy), 32'd0);
    check("done_count_0", 32'(done_cnt), 32'd2);

    run_pixels(8'd255, 2, 0, 8);
    run_pixels(8'd255, 2, 0, 8);
    drain();
    check("done_count_255x2", 32'(done_cnt), 32'd4);

    // Output back-pressure: the first result must hold and input must stall.
    run_pixels(8'd128, 0, 0, 1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd128;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'd255);
      check("stall_out_xy", {30'd0, out_x}, 32'd0);
      check("stall_out_y", 32'(out_y), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    run_pixels(8'd128, 0, 1, 7);
    drain();
    check("done_count_stall", 32'(done_cnt), 32'd5);

    // Abort at (2,1); the offered pixel in the clear cycle must be ignored.
    run_pixels(8'd128, 0, 0, 6);
    drain();
    check("busy_before_clear", 32'(busy), 32'd1);
    frame_clear = 1'b1;
    in_valid    = 1'b1;
    in_data     = 8'd0;
    @(negedge clk);
    check("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    frame_clear = 1'b0;
    in_valid    = 1'b0;
    check("clear_busy", 32'(busy), 32'd0);
    check("clear_out_valid", 32'(out_valid), 32'd0);
    run_pixels(8'd128, 0, 0, 8);
    drain();
    check("done_count_clear", 32'(done_cnt), 32'd6);

    // Asynchronous reset with a result pending in the output register.
    run_pixels(8'd128, 0, 0, 3);
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data", 32'(out_data), 32'd0);
    check("async_rst_frame_done", 32'(frame_done), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_pixels(8'd128, 0, 0, 8);
    drain();
    check("done_count_reset", 32'(done_cnt), 32'd7);

    for (int w = 0; w < 20 && sb_q.size() != 0; w++) begin
      @(posedge clk);
    end
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
